imem_loader: RTL

- Boot-time program loader sitting directly upstream of the single-cycle CPU's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Writes them to consecutive instruction-memory word addresses and verifies a trailing XOR checksum.
- Holds the CPU in reset until the image loads cleanly, then releases it.
- Any malformed image parks the block in ERROR with the CPU still held in reset.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_word_assembler.sv | 32 +++
 rtl/imem_loader.sv | 109 ++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Stream framing sizes and the loader state encoding live here.
package lib_loader;

  // Instruction memory depth, matching the single-cycle CPU's imem
  localparam int IMEM_ADDR_W    = 6;
  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } loader_state;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted bytes MSB-first into 32-bit words.
// word/word_complete are valid in the cycle the 4th byte is offered.
module word_assembler
  import lib_loader::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data,
  input  logic        accept,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_complete
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  assign word          = {shift_q, data};
  assign word_complete = accept &&
                         (cnt_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      shift_q <= {shift_q[15:0], data};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> imem words, XOR-checked,
// holding the CPU in reset until a clean image is loaded.
module imem_loader
  import lib_loader::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam logic [LEN_W-1:0] CAP = LEN_W'(2 ** ADDR_W);
  localparam logic [ADDR_W:0]  ONE = (ADDR_W + 1)'(1);

  loader_state      state;
  logic [7:0]       len_hi;
  logic [ADDR_W:0]  len_q;
  logic [ADDR_W:0]  word_cnt;
  logic [ADDR_W:0]  cnt_nxt;
  logic [7:0]       csum;
  logic [LEN_W-1:0] n_hdr;
  logic             xfer;
  logic             word_complete;
  logic [31:0]      word;

  assign rx_ready = !reset &&
                    (state != S_DONE) &&
                    (state != S_ERROR);
  assign xfer     = rx_valid && rx_ready;
  assign n_hdr    = LEN_W'({len_hi, rx_byte});
  assign cnt_nxt  = word_cnt + ONE;

  word_assembler u_asm (
    .clk           (clk),
    .reset         (reset),
    .data          (rx_byte),
    .accept        (xfer && (state == S_DATA)),
    .clear         (xfer && (state == S_LEN_LO)),
    .word          (word),
    .word_complete (word_complete)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_LEN_HI;
      len_hi     <= '0;
      len_q      <= '0;
      word_cnt   <= '0;
      csum       <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we   <= word_complete;
      done      <= (state == S_DONE);
      error     <= (state == S_ERROR);
      cpu_reset <= (state != S_DONE);
      if (word_complete) begin
        imem_waddr <= word_cnt[ADDR_W-1:0];
        imem_wdata <= word;
      end
      if (xfer) begin
        unique case (state)
          S_LEN_HI: begin
            len_hi <= rx_byte;
            state  <= S_LEN_LO;
          end
          S_LEN_LO: begin
            word_cnt <= '0;
            csum     <= '0;
            len_q    <= n_hdr[ADDR_W:0];
            if (n_hdr == '0)
              state <= S_CSUM;
            else if (n_hdr > CAP)
              state <= S_ERROR;
            else
              state <= S_DATA;
          end
          S_DATA: begin
            csum <= csum ^ rx_byte;
            if (word_complete) begin
              word_cnt <= cnt_nxt;
              if (cnt_nxt == len_q)
                state <= S_CSUM;
            end
          end
          S_CSUM: begin
            state <= (rx_byte == csum) ? S_DONE : S_ERROR;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
